// File: rtl/waveform_axi_write_arbiter.sv
// Per-burst round-robin arbiter sharing one AXI4 write master among NUM_REQ recorders.
// Optional per-requester burst counters: define WAVEFORM_ARB_STATS_EN. ROUTE_DEPTH must be a power of 2, >= 2.
module waveform_axi_write_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 35,
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned ROUTE_DEPTH    = 8
) (
  input  logic                                clk,
  input  logic                                rstN,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   s_AWADDR,
  input  logic [NUM_REQ*8-1:0]                s_AWLEN,
  input  logic [NUM_REQ-1:0]                  s_AWVALID,
  output logic [NUM_REQ-1:0]                  s_AWREADY,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   s_WDATA,
  input  logic [NUM_REQ-1:0]                  s_WLAST,
  input  logic [NUM_REQ-1:0]                  s_WVALID,
  output logic [NUM_REQ-1:0]                  s_WREADY,
  output logic [NUM_REQ*2-1:0]                s_BRESP,
  output logic [NUM_REQ-1:0]                  s_BVALID,
  output logic [AXI_ADDR_WIDTH-1:0]           m_AWADDR,
  output logic [7:0]                          m_AWLEN,
  output logic                                m_AWVALID,
  input  logic                                m_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]           m_WDATA,
  output logic                                m_WLAST,
  output logic                                m_WVALID,
  input  logic                                m_WREADY,
  input  logic [1:0]                          m_BRESP,
  input  logic                                m_BVALID,
  output logic                                m_BREADY,
  output logic [2:0]                          grantIdx,
  output logic                                busy,
  output logic                                bRouteError,
  output logic [NUM_REQ*16-1:0]               burstCount
);

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned PTR_W   = $clog2(ROUTE_DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                      r_state;
  logic [2:0]                  r_grant;
  logic [2:0]                  r_rr_ptr;
  logic [2:0]                  r_route_mem [ROUTE_DEPTH];
  logic [PTR_W:0]              r_wr_ptr;
  logic [PTR_W:0]              r_rd_ptr;

  // Requester channels widened to 8 slots so a 3-bit grant index selects exactly
  logic [AXI_ADDR_WIDTH-1:0]   w_awaddr [MAX_REQ];
  logic [7:0]                  w_awlen  [MAX_REQ];
  logic [AXI_DATA_WIDTH-1:0]   w_wdata  [MAX_REQ];
  logic [MAX_REQ-1:0]          w_awvalid;
  logic [MAX_REQ-1:0]          w_wvalid;
  logic [MAX_REQ-1:0]          w_wlast;

  logic                        w_arb_found;
  logic [2:0]                  w_arb_idx;
  logic                        w_empty;
  logic                        w_full;
  logic [2:0]                  w_head;
  logic                        w_aw_hs;
  logic                        w_w_last_hs;
  logic                        w_b_hs;
  logic [2:0]                  w_rr_next;

  always_comb begin
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      w_awaddr[3'(i)] = '0;
      w_awlen[3'(i)]  = '0;
      w_wdata[3'(i)]  = '0;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_awaddr[3'(i)] = s_AWADDR[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      w_awlen[3'(i)]  = s_AWLEN[i*8 +: 8];
      w_wdata[3'(i)]  = s_WDATA[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end
  end

  assign w_awvalid = MAX_REQ'(s_AWVALID);
  assign w_wvalid  = MAX_REQ'(s_WVALID);
  assign w_wlast   = MAX_REQ'(s_WLAST);

  // First requesting index at or above rrPtr, wrapping modulo NUM_REQ
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      logic [3:0] w_cand;
      w_cand = 4'(r_rr_ptr) + 4'(i);
      if (w_cand >= 4'(NUM_REQ)) w_cand = w_cand - 4'(NUM_REQ);
      if (!w_arb_found && w_awvalid[w_cand[2:0]]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_cand[2:0];
      end
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_head  = r_route_mem[r_rd_ptr[PTR_W-1:0]];

  assign m_AWVALID = (r_state == ADDR) && w_awvalid[r_grant];
  assign m_AWADDR  = (r_state == ADDR) ? w_awaddr[r_grant] : '0;
  assign m_AWLEN   = (r_state == ADDR) ? w_awlen[r_grant]  : '0;
  assign m_WVALID  = (r_state == DATA) && w_wvalid[r_grant];
  assign m_WDATA   = (r_state == DATA) ? w_wdata[r_grant]  : '0;
  assign m_WLAST   = (r_state == DATA) && w_wlast[r_grant];
  assign m_BREADY  = !w_empty;

  assign w_aw_hs     = m_AWVALID && m_AWREADY;
  assign w_w_last_hs = m_WVALID && m_WREADY && m_WLAST;
  assign w_b_hs      = m_BVALID && !w_empty;
  assign w_rr_next   = (r_grant == 3'(NUM_REQ-1)) ? '0 : r_grant + 3'd1;

  assign grantIdx = r_grant;
  assign busy     = (r_state != IDLE);

  always_comb begin
    s_AWREADY = '0;
    s_WREADY  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_grant == 3'(i)) begin
        s_AWREADY[i] = (r_state == ADDR) && m_AWREADY;
        s_WREADY[i]  = (r_state == DATA) && m_WREADY;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arb_found && !w_full) begin
            r_grant <= w_arb_idx;
            r_state <= ADDR;
          end
        end
        ADDR: begin
          if (w_aw_hs) r_state <= DATA;
        end
        DATA: begin
          if (w_w_last_hs) begin
            r_rr_ptr <= w_rr_next;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Route FIFO: grant index recorded at AW acceptance, consumed by each B response
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < ROUTE_DEPTH; i++) r_route_mem[i] <= '0;
    end else begin
      if (w_aw_hs) begin
        r_route_mem[r_wr_ptr[PTR_W-1:0]] <= r_grant;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_b_hs) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s_BVALID    <= '0;
      s_BRESP     <= '0;
      bRouteError <= 1'b0;
    end else begin
      s_BVALID <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_b_hs && (w_head == 3'(i))) begin
          s_BVALID[i]       <= 1'b1;
          s_BRESP[i*2 +: 2] <= m_BRESP;
        end
      end
      if (m_BVALID && w_empty) bRouteError <= 1'b1;
    end
  end

`ifdef WAVEFORM_ARB_STATS_EN
  logic [15:0] r_burst_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_burst_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_aw_hs && (r_grant == 3'(i))) r_burst_cnt[i] <= r_burst_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    burstCount = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) burstCount[i*16 +: 16] = r_burst_cnt[i];
  end
`else
  assign burstCount = '0;
`endif

endmodule

// File: tb/tb_waveform_axi_write_arbiter.sv
// Scoreboard bench for waveform_axi_write_arbiter: directed bursts, expected AW/W/B queues checked by a monitor.
module tb_waveform_axi_write_arbiter;

  localparam int NR = 4;
  localparam int AW = 35;
  localparam int DW = 128;

  logic              clk;
  logic              rstN;
  logic [NR*AW-1:0]  s_AWADDR;
  logic [NR*8-1:0]   s_AWLEN;
  logic [NR-1:0]     s_AWVALID;
  logic [NR-1:0]     s_AWREADY;
  logic [NR*DW-1:0]  s_WDATA;
  logic [NR-1:0]     s_WLAST;
  logic [NR-1:0]     s_WVALID;
  logic [NR-1:0]     s_WREADY;
  logic [NR*2-1:0]   s_BRESP;
  logic [NR-1:0]     s_BVALID;
  logic [AW-1:0]     m_AWADDR;
  logic [7:0]        m_AWLEN;
  logic              m_AWVALID;
  logic              m_AWREADY;
  logic [DW-1:0]     m_WDATA;
  logic              m_WLAST;
  logic              m_WVALID;
  logic              m_WREADY;
  logic [1:0]        m_BRESP;
  logic              m_BVALID;
  logic              m_BREADY;
  logic [2:0]        grantIdx;
  logic              busy;
  logic              bRouteError;
  logic [NR*16-1:0]  burstCount;

  logic [AW-1:0] aw_addr [NR];
  logic [7:0]    aw_len  [NR];
  logic          aw_v    [NR];
  logic [DW-1:0] w_data  [NR];
  logic          w_last  [NR];
  logic          w_v     [NR];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      s_AWADDR[i*AW +: AW] = aw_addr[i];
      s_AWLEN[i*8 +: 8]    = aw_len[i];
      s_AWVALID[i]         = aw_v[i];
      s_WDATA[i*DW +: DW]  = w_data[i];
      s_WLAST[i]           = w_last[i];
      s_WVALID[i]          = w_v[i];
    end
  end

  waveform_axi_write_arbiter #(
    .NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .ROUTE_DEPTH(8)
  ) dut (
    .clk(clk), .rstN(rstN),
    .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
    .s_WDATA(s_WDATA), .s_WLAST(s_WLAST), .s_WVALID(s_WVALID), .s_WREADY(s_WREADY),
    .s_BRESP(s_BRESP), .s_BVALID(s_BVALID),
    .m_AWADDR(m_AWADDR), .m_AWLEN(m_AWLEN), .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
    .m_WDATA(m_WDATA), .m_WLAST(m_WLAST), .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
    .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
    .grantIdx(grantIdx), .busy(busy), .bRouteError(bRouteError), .burstCount(burstCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [1:0] req; logic [AW-1:0] addr; logic [7:0] len; } aw_exp_t;
  typedef struct { logic [DW-1:0] data; logic last; } w_exp_t;
  typedef struct { logic [1:0] req; logic [1:0] resp; } b_exp_t;

  aw_exp_t aw_q [$];
  w_exp_t  w_q  [$];
  b_exp_t  b_q  [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for handshake at %0t", name, $time);
  endtask

  task automatic exp_burst(input logic [1:0] k, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [DW-1:0] d0);
    aw_exp_t a;
    w_exp_t  w;
    a.req = k; a.addr = addr; a.len = len;
    aw_q.push_back(a);
    for (int b = 0; b <= int'(len); b++) begin
      w.data = d0 + DW'(b);
      w.last = (b == int'(len));
      w_q.push_back(w);
    end
  endtask

  task automatic exp_b(input logic [1:0] k, input logic [1:0] resp);
    b_exp_t e;
    e.req = k; e.resp = resp;
    b_q.push_back(e);
  endtask

  // Requester model; entered and left just after a rising edge
  task automatic req_burst(input logic [1:0] k, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [DW-1:0] d0);
    int n;
    aw_addr[k] = addr; aw_len[k] = len; aw_v[k] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_AWREADY[k]) break;
      if (++n > 200) begin
        timeout_fail("req_aw");
        aw_v[k] = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    aw_v[k] = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      w_data[k] = d0 + DW'(b);
      w_last[k] = (b == int'(len));
      w_v[k]    = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (s_WREADY[k]) break;
        if (++n > 200) begin
          timeout_fail("req_w");
          w_v[k] = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    w_v[k] = 1'b0;
    w_last[k] = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] resp);
    int n;
    m_BRESP = resp; m_BVALID = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (m_BREADY) break;
      if (++n > 200) begin
        timeout_fail("send_b");
        break;
      end
    end
    @(posedge clk); #1;
    m_BVALID = 1'b0; m_BRESP = 2'b00;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rstN = 1'b0;
    @(posedge clk); #1 rstN = 1'b1;
  endtask

  // Monitor: pops and compares whenever the DUT presents a handshake or response
  initial begin
    logic [3:0] oh;
    aw_exp_t a;
    w_exp_t  w;
    b_exp_t  b;
    forever begin
      @(negedge clk);
      if (rstN) begin
        oh = 4'b0001 << grantIdx;
        chk("nongrant_awready", 128'(s_AWREADY & ~oh), '0);
        chk("nongrant_wready",  128'(s_WREADY & ~oh), '0);
        if (m_AWVALID && m_AWREADY) begin
          if (aw_q.size() == 0) begin
            chk("aw_unexpected", 128'(m_AWADDR), '1);
          end else begin
            a = aw_q.pop_front();
            chk("aw_grant", 128'(grantIdx), 128'(a.req));
            chk("aw_addr",  128'(m_AWADDR), 128'(a.addr));
            chk("aw_len",   128'(m_AWLEN),  128'(a.len));
          end
        end
        if (m_WVALID && m_WREADY) begin
          if (w_q.size() == 0) begin
            chk("w_unexpected", m_WDATA, '1);
          end else begin
            w = w_q.pop_front();
            chk("w_data", m_WDATA, w.data);
            chk("w_last", 128'(m_WLAST), 128'(w.last));
          end
        end
        if (s_BVALID != '0) begin
          if (b_q.size() == 0) begin
            chk("b_unexpected", 128'(s_BVALID), '0);
          end else begin
            b = b_q.pop_front();
            chk("b_route", 128'(s_BVALID), 128'(4'b0001 << b.req));
            chk("b_resp",  128'((s_BRESP >> (2 * int'(b.req))) & 8'h3), 128'(b.resp));
          end
        end
      end
    end
  end

  initial begin
    int n;
    rstN = 1'b0;
    m_AWREADY = 1'b1; m_WREADY = 1'b1; m_BVALID = 1'b0; m_BRESP = 2'b00;
    for (int i = 0; i < NR; i++) begin
      aw_addr[i] = '0; aw_len[i] = '0; aw_v[i] = 1'b0;
      w_data[i] = '0; w_last[i] = 1'b0; w_v[i] = 1'b0;
    end

    repeat (2) @(negedge clk);
    chk("rst_busy",   128'(busy), '0);
    chk("rst_grant",  128'(grantIdx), '0);
    chk("rst_awvalid", 128'(m_AWVALID), '0);
    chk("rst_wvalid", 128'(m_WVALID), '0);
    chk("rst_bready", 128'(m_BREADY), '0);
    chk("rst_bvalid", 128'(s_BVALID), '0);
    chk("rst_bresp",  128'(s_BRESP), '0);
    chk("rst_rerr",   128'(bRouteError), '0);
    chk("rst_count",  128'(burstCount), '0);
    @(posedge clk); #1 rstN = 1'b1;

    // Single requester: 2 issues AWLEN=3 at 0x10000
    exp_burst(2'd2, 35'h10000, 8'd3, 128'h2000);
    fork
      req_burst(2'd2, 35'h10000, 8'd3, 128'h2000);
    join_none
    @(negedge clk);
    chk("arb_lat_idle", 128'(m_AWVALID), '0);
    @(negedge clk);
    chk("arb_lat_addr", 128'(m_AWVALID), 128'(1));
    chk("arb_lat_aw",   128'(m_AWADDR), 128'h10000);
    wait fork;
    chk("single_bready", 128'(m_BREADY), 128'(1));
    exp_b(2'd2, 2'd0);
    send_b(2'd0);
    @(negedge clk);
    chk("b_pulse_hi", 128'(s_BVALID), 128'(4'b0100));
    @(negedge clk);
    chk("b_pulse_lo", 128'(s_BVALID), '0);

    // Fairness: all four requesting, grants 0,1,2,3,0,1
    pulse_reset();
    exp_burst(2'd0, 35'h1000, 8'd0, 128'h0100);
    exp_burst(2'd1, 35'h1100, 8'd0, 128'h1100);
    exp_burst(2'd2, 35'h1200, 8'd0, 128'h2100);
    exp_burst(2'd3, 35'h1300, 8'd0, 128'h3100);
    exp_burst(2'd0, 35'h1010, 8'd0, 128'h0200);
    exp_burst(2'd1, 35'h1110, 8'd0, 128'h1200);
    fork
      begin
        req_burst(2'd0, 35'h1000, 8'd0, 128'h0100);
        req_burst(2'd0, 35'h1010, 8'd0, 128'h0200);
      end
      begin
        req_burst(2'd1, 35'h1100, 8'd0, 128'h1100);
        req_burst(2'd1, 35'h1110, 8'd0, 128'h1200);
      end
      req_burst(2'd2, 35'h1200, 8'd0, 128'h2100);
      req_burst(2'd3, 35'h1300, 8'd0, 128'h3100);
    join
`ifdef WAVEFORM_ARB_STATS_EN
    chk("fair_counts", 128'(burstCount), 128'({16'd1, 16'd1, 16'd2, 16'd2}));
`else
    chk("fair_counts", 128'(burstCount), '0);
`endif
    exp_b(2'd0, 2'd0); exp_b(2'd1, 2'd1); exp_b(2'd2, 2'd2);
    exp_b(2'd3, 2'd3); exp_b(2'd0, 2'd0); exp_b(2'd1, 2'd1);
    send_b(2'd0); send_b(2'd1); send_b(2'd2);
    send_b(2'd3); send_b(2'd0); send_b(2'd1);

    // Backpressure: rrPtr is 2, so requester 3 wins over 1
    exp_burst(2'd3, 35'h30000, 8'd2, 128'h3300);
    exp_burst(2'd1, 35'h31000, 8'd3, 128'h1300);
    m_AWREADY = 1'b0;
    fork
      req_burst(2'd3, 35'h30000, 8'd2, 128'h3300);
      req_burst(2'd1, 35'h31000, 8'd3, 128'h1300);
    join_none
    repeat (5) @(negedge clk);
    chk("bp_aw_held",  128'(m_AWVALID), 128'(1));
    chk("bp_grant",    128'(grantIdx), 128'(3));
    chk("bp_awready",  128'(s_AWREADY), '0);
    @(posedge clk); #1 m_AWREADY = 1'b1;
    repeat (30) begin
      @(posedge clk); #1 m_WREADY = ~m_WREADY;
    end
    m_WREADY = 1'b1;
    wait fork;
    exp_b(2'd3, 2'd2); exp_b(2'd1, 2'd1);
    send_b(2'd2); send_b(2'd1);

    // Route FIFO full: eight bursts outstanding block the ninth
    for (int i = 0; i < 8; i++) begin
      exp_burst(2'd0, AW'(32'h40000 + i * 32'h40), 8'd0, DW'(32'h5000 + i));
      req_burst(2'd0, AW'(32'h40000 + i * 32'h40), 8'd0, DW'(32'h5000 + i));
    end
    exp_burst(2'd1, 35'h48000, 8'd1, 128'h6000);
    fork
      req_burst(2'd1, 35'h48000, 8'd1, 128'h6000);
    join_none
    repeat (4) begin
      @(negedge clk);
      chk("full_idle",    128'(busy), '0);
      chk("full_awvalid", 128'(m_AWVALID), '0);
    end
    @(posedge clk); #1;
    exp_b(2'd0, 2'd0);
    send_b(2'd0);
    wait fork;
    for (int i = 1; i < 8; i++) exp_b(2'd0, 2'(i));
    exp_b(2'd1, 2'd3);
    for (int i = 1; i < 8; i++) send_b(2'(i));
    send_b(2'd3);

    // B with empty route FIFO
    chk("empty_bready", 128'(m_BREADY), '0);
    m_BVALID = 1'b1; m_BRESP = 2'd2;
    @(posedge clk); #1 m_BVALID = 1'b0; m_BRESP = 2'd0;
    @(negedge clk);
    chk("route_err", 128'(bRouteError), 128'(1));

    // Reset in DATA abandons the burst; rrPtr returns to 0
    m_WREADY = 1'b0;
    exp_burst(2'd2, 35'h50000, 8'd3, 128'h7000);
    void'(w_q.pop_back()); void'(w_q.pop_back()); void'(w_q.pop_back()); void'(w_q.pop_back());
    aw_addr[2] = 35'h50000; aw_len[2] = 8'd3; aw_v[2] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_AWREADY[2] && n < 20);
    chk("rst_test_grant", 128'(s_AWREADY[2]), 128'(1));
    @(posedge clk); #1;
    aw_v[2] = 1'b0; w_data[2] = 128'h7000; w_v[2] = 1'b1;
    @(negedge clk);
    chk("data_busy",   128'(busy), 128'(1));
    chk("data_wvalid", 128'(m_WVALID), 128'(1));
    @(posedge clk); #1 rstN = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy",   128'(busy), '0);
    chk("mid_rst_wvalid", 128'(m_WVALID), '0);
    chk("mid_rst_grant",  128'(grantIdx), '0);
    chk("mid_rst_rerr",   128'(bRouteError), '0);
    chk("mid_rst_count",  128'(burstCount), '0);
    chk("mid_rst_wready", 128'(s_WREADY), '0);
    @(posedge clk); #1 rstN = 1'b1;
    w_v[2] = 1'b0; m_WREADY = 1'b1;
    exp_burst(2'd1, 35'h60000, 8'd0, 128'h8100);
    exp_burst(2'd3, 35'h63000, 8'd0, 128'h8300);
    fork
      req_burst(2'd1, 35'h60000, 8'd0, 128'h8100);
      req_burst(2'd3, 35'h63000, 8'd0, 128'h8300);
    join
    exp_b(2'd1, 2'd1); exp_b(2'd3, 2'd0);
    send_b(2'd1); send_b(2'd0);
    repeat (3) @(negedge clk);

    chk("aw_q_drained", 128'(aw_q.size()), '0);
    chk("w_q_drained",  128'(w_q.size()), '0);
    chk("b_q_drained",  128'(b_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
